// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  // Instructions are fixed-width words; the PC advances by one word per fetch.
  localparam int INSTR_BYTES = 4;

  localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetch queue entry: the PC the word was fetched from plus the word.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry circular buffer of fetch entries with synchronous flush.
// Latency: 1 cycle push-to-head; head is a registered entry, no bypass.
// Backpressure: none internally; the caller must not push when full unless popping.
//
// Ports: clk/rst_n; push + push_dat write the tail; pop advances the head;
// flush empties the buffer (wins over push/pop); head_dat is the oldest
// entry; count is the number of occupied entries (0..DEPTH).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_dat,
  input  logic          pop,
  input  logic          flush,
  output entry_t        head_dat,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads the ROM every cycle, queues words for decode.
// Latency: 1 cycle from ROM fetch to head-valid; 1 instruction/cycle sustained with ready high.
// Backpressure: decode ready low fills the queue to DEPTH, then the PC holds until a pop.
//
// Ports: iClk/iRstN; oRomAddr/iRomData combinational ROM read; iFetchEn gates
// fetching; iRedirect/iRedirectPC flush and restart; oInstrValid/iInstrReady
// with oInstr/oInstrPC is the decode handshake; oCount is queue occupancy.
module fetch_prefetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  output logic [ADDR_WIDTH-1:0]    oRomAddr,
  input  logic [DATA_WIDTH-1:0]    iRomData,
  input  logic                     iFetchEn,
  input  logic                     iRedirect,
  input  logic [ADDR_WIDTH-1:0]    iRedirectPC,
  output logic                     oInstrValid,
  input  logic                     iInstrReady,
  output logic [DATA_WIDTH-1:0]    oInstr,
  output logic [ADDR_WIDTH-1:0]    oInstrPC,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  full;
  logic                  push;
  logic                  pop;
  entry_t                tail_dat;
  entry_t                head_dat;

  // The PC register drives the ROM directly so the ROM read path starts at a flop.
  assign oRomAddr = pc_q;

  assign oInstrValid = (oCount != '0);
  assign full        = (oCount == CW'(DEPTH));

  // A redirect kills the head presented this cycle, so it is never popped.
  assign pop  = oInstrValid && iInstrReady && !iRedirect;
  // A full queue can still accept a word when the head leaves in the same cycle.
  assign push = iFetchEn && !iRedirect && (!full || pop);

  // Redirect targets are forced to word alignment; PC wraps modulo 2^ADDR_WIDTH.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc_q <= RESET_PC;
    end else if (iRedirect) begin
      pc_q <= iRedirectPC & ~ADDR_WIDTH'(INSTR_BYTES - 1);
    end else if (push) begin
      pc_q <= pc_q + ADDR_WIDTH'(INSTR_BYTES);
    end
  end

  assign tail_dat = '{pc: pc_q, instr: iRomData};

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fetch_fifo (
    .clk      (iClk),
    .rst_n    (iRstN),
    .push     (push),
    .push_dat (tail_dat),
    .pop      (pop),
    .flush    (iRedirect),
    .head_dat (head_dat),
    .count    (oCount)
  );

  assign oInstr   = head_dat.instr;
  assign oInstrPC = head_dat.pc;

endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Directed bench for fetch_prefetch_ctrl: the ROM returns its own byte address
// as the instruction word, so every queued entry must carry instr == pc.
module tb_fetch_prefetch_ctrl;

  logic        iClk;
  logic        iRstN;
  logic [31:0] oRomAddr;
  logic [31:0] iRomData;
  logic        iFetchEn;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        oInstrValid;
  logic        iInstrReady;
  logic [31:0] oInstr;
  logic [31:0] oInstrPC;
  logic [2:0]  oCount;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_prefetch_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .iClk        (iClk),
    .iRstN       (iRstN),
    .oRomAddr    (oRomAddr),
    .iRomData    (iRomData),
    .iFetchEn    (iFetchEn),
    .iRedirect   (iRedirect),
    .iRedirectPC (iRedirectPC),
    .oInstrValid (oInstrValid),
    .iInstrReady (iInstrReady),
    .oInstr      (oInstr),
    .oInstrPC    (oInstrPC),
    .oCount      (oCount)
  );

  // ROM model: word at byte address k is k.
  assign iRomData = oRomAddr;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    iRstN       = 1'b0;
    iFetchEn    = 1'b1;
    iRedirect   = 1'b0;
    iRedirectPC = 32'h0;
    iInstrReady = 1'b1;

    // Reset state
    #12;
    check_eq("rst_romaddr", oRomAddr, 32'h0);
    check_eq("rst_valid", oInstrValid, 1'b0);
    check_eq("rst_count", oCount, 3'd0);
    check_eq("rst_instr", oInstr, 32'h0);
    check_eq("rst_instrpc", oInstrPC, 32'h0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;

    // Streaming with ready high: heads 0,4,8,12 on consecutive cycles
    tick();
    check_eq("stream_count", oCount, 3'd1);
    check_eq("stream_romaddr", oRomAddr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      check_eq("stream_valid", oInstrValid, 1'b1);
      check_eq("stream_pc", oInstrPC, 32'(4 * i));
      check_eq("stream_instr", oInstr, 32'(4 * i));
      tick();
    end

    // Back-pressure: restart at 0, hold ready low 10 cycles
    iRedirect   = 1'b1;
    iRedirectPC = 32'h0;
    iInstrReady = 1'b0;
    tick();
    iRedirect = 1'b0;
    check_eq("bp_flush_valid", oInstrValid, 1'b0);
    check_eq("bp_flush_romaddr", oRomAddr, 32'h0);
    repeat (10) tick();
    check_eq("bp_count_sat", oCount, 3'd4);
    check_eq("bp_romaddr_hold", oRomAddr, 32'h10);
    check_eq("bp_head_hold", oInstrPC, 32'h0);
    iInstrReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_drain_pc", oInstrPC, 32'(4 * i));
      tick();
      if (i == 0) check_eq("bp_full_pushpop_count", oCount, 3'd4);
    end

    // Redirect with 3 entries queued
    iFetchEn = 1'b0;
    tick();
    check_eq("rd_pre_count", oCount, 3'd3);
    iFetchEn    = 1'b1;
    iRedirect   = 1'b1;
    iRedirectPC = 32'h0000_0103;
    tick();
    iRedirect = 1'b0;
    check_eq("rd_valid", oInstrValid, 1'b0);
    check_eq("rd_count", oCount, 3'd0);
    check_eq("rd_romaddr", oRomAddr, 32'h100);
    tick();
    check_eq("rd_head_valid", oInstrValid, 1'b1);
    check_eq("rd_head_pc", oInstrPC, 32'h100);
    check_eq("rd_head_instr", oInstr, 32'h100);

    // Redirect while valid && ready: head discarded, fetch restarts
    iRedirect   = 1'b1;
    iRedirectPC = 32'h0000_0200;
    tick();
    iRedirect = 1'b0;
    check_eq("rdvr_count", oCount, 3'd0);
    check_eq("rdvr_romaddr", oRomAddr, 32'h200);
    tick();
    check_eq("rdvr_head_pc", oInstrPC, 32'h200);

    // Fetch disabled: queue of 2 drains, PC held
    iInstrReady = 1'b0;
    tick();
    check_eq("fe_count2", oCount, 3'd2);
    iInstrReady = 1'b1;
    iFetchEn    = 1'b0;
    repeat (5) tick();
    check_eq("fe_drained_count", oCount, 3'd0);
    check_eq("fe_drained_valid", oInstrValid, 1'b0);
    check_eq("fe_romaddr_hold", oRomAddr, 32'h208);
    iFetchEn = 1'b1;
    tick();
    check_eq("fe_resume_valid", oInstrValid, 1'b1);
    check_eq("fe_resume_pc", oInstrPC, 32'h208);

    // PC wrap at top of address space
    iRedirect   = 1'b1;
    iRedirectPC = 32'hFFFF_FFF8;
    tick();
    iRedirect = 1'b0;
    tick();
    check_eq("wrap_pc0", oInstrPC, 32'hFFFF_FFF8);
    tick();
    check_eq("wrap_pc1", oInstrPC, 32'hFFFF_FFFC);
    tick();
    check_eq("wrap_pc2", oInstrPC, 32'h0);
    check_eq("wrap_instr2", oInstr, 32'h0);
    check_eq("wrap_romaddr", oRomAddr, 32'h4);

    // Asynchronous reset mid-stream, observed before the next edge
    iRstN = 1'b0;
    #1;
    check_eq("arst_valid", oInstrValid, 1'b0);
    check_eq("arst_romaddr", oRomAddr, 32'h0);
    check_eq("arst_count", oCount, 3'd0);
    #1;
    iRstN = 1'b1;
    tick();
    check_eq("post_rst_valid", oInstrValid, 1'b1);
    check_eq("post_rst_pc", oInstrPC, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
